data_mem_ctrl: RTL and testbench

- Parametrised successor of the data memory front-end: one registered request slot serving two requesters, the core pipeline and the I/O loader.
- Addresses below LOCAL_BYTES go to on-chip block RAM with a configurable read latency; all other addresses go to the external DRAM port through a valid/ready handshake.
- New over the previous generation: latched requests, byte-strobe writes, configurable local latency, a DRAM timeout with error flag, and a per-requester busy/response handshake.

---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between one requester (core or I/O loader) and the
// data memory front-end.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                req_valid;
  logic                req_we;
  logic [DATA_W/8-1:0] req_strb;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                busy;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_strb, req_addr, req_wdata,
    input  busy, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_strb, req_addr, req_wdata,
    output busy, resp_valid, resp_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory front-end: one latched request slot shared by the core and the
// I/O loader, steering each access to local block RAM or the external DRAM.
module data_mem_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LOCAL_BYTES  = 16384,
  parameter int LOCAL_RD_LAT = 2,
  parameter int DRAM_ADDR_W  = 27,
  parameter int TIMEOUT      = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           core_owns,
  data_mem_ctrl_if.slave                 core,
  data_mem_ctrl_if.slave                 io,
  output logic [DATA_W/8-1:0]            bram_we,
  output logic [$clog2(LOCAL_BYTES)-3:0] bram_addr,
  output logic [DATA_W-1:0]              bram_din,
  input  logic [DATA_W-1:0]              bram_dout,
  output logic                           dram_valid,
  output logic                           dram_rw,
  output logic [DRAM_ADDR_W-1:0]         dram_addr,
  output logic [DATA_W-1:0]              dram_din,
  input  logic [DATA_W-1:0]              dram_dout,
  input  logic                           dram_ready,
  output logic                           err_timeout
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LB_W   = $clog2(LOCAL_BYTES);
  localparam int RD_W   = $clog2(LOCAL_RD_LAT + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LOCAL_LIMIT = ADDR_W'(LOCAL_BYTES);

  typedef enum logic [2:0] {IDLE, L_WR, L_RD, D_REQ, RESP} state_t;

  state_t state;
  state_t state_next;

  logic                   sel_valid;
  logic                   sel_we;
  logic [STRB_W-1:0]      sel_strb;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_local;

  logic                   lat_we;
  logic [STRB_W-1:0]      lat_strb;
  logic [DRAM_ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0]      lat_wdata;
  logic                   lat_core;
  logic [DATA_W-1:0]      rdata_q;
  logic [RD_W-1:0]        rd_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic                   rd_done;
  logic                   to_expire;

  assign sel_valid = core_owns ? core.req_valid : io.req_valid;
  assign sel_we    = core_owns ? core.req_we    : io.req_we;
  assign sel_strb  = core_owns ? core.req_strb  : io.req_strb;
  assign sel_addr  = core_owns ? core.req_addr  : io.req_addr;
  assign sel_wdata = core_owns ? core.req_wdata : io.req_wdata;
  assign sel_local = (sel_addr < LOCAL_LIMIT);

  assign rd_done   = (rd_cnt == RD_W'(LOCAL_RD_LAT - 1));
  assign to_expire = (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // In IDLE the BRAM already sees the incoming address so read data lines up
  // with the configured latency; busy and bram_addr are held low during reset.
  always_comb begin
    state_next      = state;
    bram_we         = '0;
    bram_addr       = '0;
    bram_din        = '0;
    dram_valid      = 1'b0;
    dram_rw         = 1'b0;
    dram_addr       = '0;
    dram_din        = '0;
    core.busy       = 1'b1;
    io.busy         = 1'b1;
    core.resp_valid = 1'b0;
    io.resp_valid   = 1'b0;
    core.resp_rdata = '0;
    io.resp_rdata   = '0;
    unique case (state)
      IDLE: begin
        core.busy = rstn & ~core_owns;
        io.busy   = rstn & core_owns;
        if (rstn) bram_addr = sel_addr[LB_W-1:2];
        if (sel_valid) begin
          if (!sel_local)  state_next = D_REQ;
          else if (sel_we) state_next = L_WR;
          else             state_next = L_RD;
        end
      end
      L_WR: begin
        bram_we    = lat_strb;
        bram_addr  = lat_addr[LB_W-1:2];
        bram_din   = lat_wdata;
        state_next = RESP;
      end
      L_RD: begin
        bram_addr = lat_addr[LB_W-1:2];
        if (rd_done) state_next = RESP;
      end
      D_REQ: begin
        dram_valid = 1'b1;
        dram_rw    = lat_we;
        dram_addr  = lat_addr;
        dram_din   = lat_wdata;
        if (dram_ready || to_expire) state_next = RESP;
      end
      RESP: begin
        if (lat_core) begin
          core.resp_valid = 1'b1;
          core.resp_rdata = rdata_q;
        end else begin
          io.resp_valid = 1'b1;
          io.resp_rdata = rdata_q;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request slot, read-data capture and the two wait counters; ready beats a
  // simultaneous timeout terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_we      <= 1'b0;
      lat_strb    <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_core    <= 1'b0;
      rdata_q     <= '0;
      rd_cnt      <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && sel_valid) begin
        lat_we    <= sel_we;
        lat_strb  <= sel_strb;
        lat_addr  <= sel_addr[DRAM_ADDR_W-1:0];
        lat_wdata <= sel_wdata;
        lat_core  <= core_owns;
        rdata_q   <= '0;
      end
      if (state == L_RD && rd_done)
        rdata_q <= bram_dout;
      if (state == D_REQ && dram_ready && !lat_we)
        rdata_q <= dram_dout;
      if (state == D_REQ && !dram_ready && to_expire)
        err_timeout <= 1'b1;
      rd_cnt <= (state == L_RD)  ? rd_cnt + RD_W'(1) : '0;
      to_cnt <= (state == D_REQ) ? to_cnt + TO_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: local and DRAM accesses, byte strobes,
// region boundary, DRAM timeout, port ownership and asynchronous reset.
module tb_data_mem_ctrl;
  logic        clk;
  logic        rstn;
  logic        core_owns;
  logic [3:0]  bram_we;
  logic [11:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic        dram_valid;
  logic        dram_rw;
  logic [26:0] dram_addr;
  logic [31:0] dram_din;
  logic [31:0] dram_dout;
  logic        dram_ready;
  logic        err_timeout;

  int checks;
  int failures;
  int dram_delay;
  int dcnt;
  int peak_valid;
  int core_resp_cnt;
  int io_resp_cnt;
  logic        seen_rw;
  logic [26:0] seen_addr;
  logic [31:0] seen_din;

  logic [31:0] bram_mem [0:4095];
  logic [31:0] rd_s1;
  logic [31:0] rd_s2;

  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) core_bus ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) io_bus ();

  data_mem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .LOCAL_BYTES(16384),
    .LOCAL_RD_LAT(2), .DRAM_ADDR_W(27), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .core_owns(core_owns),
    .core(core_bus), .io(io_bus),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout),
    .dram_valid(dram_valid), .dram_rw(dram_rw), .dram_addr(dram_addr),
    .dram_din(dram_din), .dram_dout(dram_dout), .dram_ready(dram_ready),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage synchronous block RAM with byte enables.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
    rd_s1 <= bram_mem[bram_addr];
    rd_s2 <= rd_s1;
  end
  assign bram_dout = rd_s2;

  // DRAM responder: raises ready in the dram_delay-th cycle of valid (0 = never).
  always @(negedge clk) begin
    if (dram_valid) begin
      dcnt++;
      if (dcnt > peak_valid) peak_valid = dcnt;
      seen_rw   = dram_rw;
      seen_addr = dram_addr;
      seen_din  = dram_din;
      dram_ready = (dram_delay != 0 && dcnt == dram_delay);
    end else begin
      dcnt = 0;
      dram_ready = 1'b0;
    end
    if (core_bus.resp_valid === 1'b1) core_resp_cnt++;
    if (io_bus.resp_valid === 1'b1)   io_resp_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One access on the chosen port; lat counts cycles from the accepting edge
  // to the cycle where resp_valid is seen.
  task automatic applyStimulus(input bit use_core, input bit we, input logic [3:0] strb,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int lat);
    int  n;
    bit  seen;
    peak_valid = 0;
    @(posedge clk); #1;
    if (use_core) begin
      core_bus.req_valid = 1'b1; core_bus.req_we = we; core_bus.req_strb = strb;
      core_bus.req_addr = addr;  core_bus.req_wdata = wdata;
    end else begin
      io_bus.req_valid = 1'b1; io_bus.req_we = we; io_bus.req_strb = strb;
      io_bus.req_addr = addr;  io_bus.req_wdata = wdata;
    end
    @(posedge clk); #1;
    core_bus.req_valid = 1'b0;
    io_bus.req_valid   = 1'b0;
    n = 1;
    seen = 1'b0;
    rdata = '0;
    while (!seen && n <= 40) begin
      @(negedge clk);
      if (use_core ? core_bus.resp_valid : io_bus.resp_valid) begin
        seen = 1'b1;
        rdata = use_core ? core_bus.resp_rdata : io_bus.resp_rdata;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    lat = seen ? n : -1;
    checkOutput("resp_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          seen;
    checks = 0; failures = 0;
    dram_delay = 0; dcnt = 0; peak_valid = 0;
    core_resp_cnt = 0; io_resp_cnt = 0;
    dram_ready = 1'b0; dram_dout = 32'h0;
    rstn = 1'b0; core_owns = 1'b1;
    core_bus.req_valid = 1'b0; core_bus.req_we = 1'b0; core_bus.req_strb = 4'h0;
    core_bus.req_addr = 32'h100; core_bus.req_wdata = 32'h0;
    io_bus.req_valid = 1'b0; io_bus.req_we = 1'b0; io_bus.req_strb = 4'h0;
    io_bus.req_addr = 32'h0; io_bus.req_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy_core", 32'(core_bus.busy), 32'd0);
    checkOutput("rst_busy_io", 32'(io_bus.busy), 32'd0);
    checkOutput("rst_bram_addr", 32'(bram_addr), 32'd0);
    checkOutput("rst_dram_valid", 32'(dram_valid), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    core_bus.req_addr = 32'h0;
    @(negedge clk);
    checkOutput("idle_busy_core", 32'(core_bus.busy), 32'd0);
    checkOutput("idle_busy_io", 32'(io_bus.busy), 32'd1);

    applyStimulus(1, 1, 4'hF, 32'h100, 32'hDEADBEEF, rd, lat);
    checkOutput("lwr_lat", 32'(lat), 32'd2);
    checkOutput("lwr_rdata", rd, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, rd, lat);
    checkOutput("lrd_lat", 32'(lat), 32'd3);
    checkOutput("lrd_rdata", rd, 32'hDEADBEEF);

    applyStimulus(1, 1, 4'hF, 32'h40, 32'h11223344, rd, lat);
    applyStimulus(1, 1, 4'h1, 32'h40, 32'h000000AA, rd, lat);
    applyStimulus(1, 0, 4'hF, 32'h43, 32'h0, rd, lat);
    checkOutput("strb_rdata", rd, 32'h112233AA);

    dram_delay = 7; dram_dout = 32'hCAFEF00D;
    applyStimulus(1, 0, 4'hF, 32'h00010000, 32'h0, rd, lat);
    checkOutput("drd_lat", 32'(lat), 32'd8);
    checkOutput("drd_valid_cycles", 32'(peak_valid), 32'd7);
    checkOutput("drd_addr", 32'(seen_addr), 32'h0010000);
    checkOutput("drd_rdata", rd, 32'hCAFEF00D);
    checkOutput("drd_valid_drop", 32'(dram_valid), 32'd0);

    dram_delay = 3;
    applyStimulus(1, 1, 4'h1, 32'h00020000, 32'h55667788, rd, lat);
    checkOutput("dwr_lat", 32'(lat), 32'd4);
    checkOutput("dwr_rw", 32'(seen_rw), 32'd1);
    checkOutput("dwr_din", seen_din, 32'h55667788);
    checkOutput("dwr_rdata", rd, 32'h0);

    applyStimulus(1, 1, 4'hF, 32'h3FFC, 32'hAABBCCDD, rd, lat);
    checkOutput("b3ffc_wr_lat", 32'(lat), 32'd2);
    applyStimulus(1, 0, 4'hF, 32'h3FFC, 32'h0, rd, lat);
    checkOutput("b3ffc_no_dram", 32'(peak_valid), 32'd0);
    checkOutput("b3ffc_rdata", rd, 32'hAABBCCDD);
    dram_delay = 1; dram_dout = 32'h12345678;
    applyStimulus(1, 0, 4'hF, 32'h4000, 32'h0, rd, lat);
    checkOutput("b4000_lat", 32'(lat), 32'd2);
    checkOutput("b4000_addr", 32'(seen_addr), 32'h0004000);
    checkOutput("b4000_rdata", rd, 32'h12345678);

    checkOutput("err_before_to", 32'(err_timeout), 32'd0);
    dram_delay = 0; dram_dout = 32'hFFFFFFFF;
    applyStimulus(1, 0, 4'hF, 32'h00800000, 32'h0, rd, lat);
    checkOutput("to_lat", 32'(lat), 32'd17);
    checkOutput("to_valid_cycles", 32'(peak_valid), 32'd16);
    checkOutput("to_valid_drop", 32'(dram_valid), 32'd0);
    checkOutput("to_err", 32'(err_timeout), 32'd1);
    checkOutput("to_rdata", rd, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, rd, lat);
    checkOutput("to_err_sticky", 32'(err_timeout), 32'd1);

    // Both ports request with io selected; ownership flips after accept.
    @(posedge clk); #1;
    core_owns = 1'b0;
    io_bus.req_valid = 1'b1; io_bus.req_we = 1'b0; io_bus.req_strb = 4'hF;
    io_bus.req_addr = 32'h100;
    core_bus.req_valid = 1'b1; core_bus.req_we = 1'b0; core_bus.req_strb = 4'hF;
    core_bus.req_addr = 32'h40;
    core_resp_cnt = 0; io_resp_cnt = 0;
    @(negedge clk);
    checkOutput("own_busy_core", 32'(core_bus.busy), 32'd1);
    checkOutput("own_busy_io_idle", 32'(io_bus.busy), 32'd0);
    @(posedge clk); #1;
    io_bus.req_valid = 1'b0;
    core_owns = 1'b1;
    @(negedge clk);
    checkOutput("own_busy_io_active", 32'(io_bus.busy), 32'd1);
    seen = 1'b0;
    rd = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (io_bus.resp_valid) begin
        seen = 1'b1;
        rd = io_bus.resp_rdata;
        core_bus.req_valid = 1'b0;
      end
    end
    core_bus.req_valid = 1'b0;
    checkOutput("own_io_resp", 32'(seen), 32'd1);
    checkOutput("own_io_rdata", rd, 32'hDEADBEEF);
    repeat (4) @(negedge clk);
    checkOutput("own_core_quiet", 32'(core_resp_cnt), 32'd0);

    // Reset in the middle of a DRAM wait.
    dram_delay = 0;
    @(posedge clk); #1;
    core_bus.req_valid = 1'b1; core_bus.req_we = 1'b0; core_bus.req_addr = 32'h00900000;
    @(posedge clk); #1;
    core_bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_dram_valid", 32'(dram_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_dram_valid", 32'(dram_valid), 32'd0);
    checkOutput("arst_dram_addr", 32'(dram_addr), 32'd0);
    checkOutput("arst_err", 32'(err_timeout), 32'd0);
    checkOutput("arst_busy_io", 32'(io_bus.busy), 32'd0);
    core_resp_cnt = 0; io_resp_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("arst_no_resp", 32'(core_resp_cnt + io_resp_cnt), 32'd0);
    applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, rd, lat);
    checkOutput("post_rst_lat", 32'(lat), 32'd3);
    checkOutput("post_rst_rdata", rd, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
